// File: rtl/instr_sequencer.sv
// instr_sequencer: ready-driven FSM stepping each instruction through fetch, decode,
// execute, memory and write-back, with memory handshake timeout and retire counting.
module instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [1:0] SM,
  input  logic [3:0] OP,
  input  logic [2:0] FLAG_ALU,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       reg_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [2:0] phase,
  output logic       fault,
  output logic [7:0] instr_cnt
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  state_t     state_q, state_d, next_instr;
  logic [7:0] wait_q, wait_d, instr_cnt_q, instr_cnt_d;
  logic       fault_q, fault_d;
  logic       is_flow, legal, is_ldm, is_stm, is_cmp, is_jmp, is_jz, retire, timeout;
  logic       flag_unused;

  assign flag_unused = ^FLAG_ALU[2:1];

  always_comb begin
    is_flow    = SM == 2'b11;
    legal      = SM == 2'b10 || (is_flow ? OP < 4'd2 : OP < 4'd3);
    is_ldm     = SM == 2'b00 && OP == 4'd1;
    is_stm     = SM == 2'b00 && OP == 4'd2;
    is_cmp     = SM == 2'b01 && OP == 4'd0;
    is_jmp     = is_flow && OP == 4'd0;
    is_jz      = is_flow && OP == 4'd1;
    timeout    = wait_q == 8'(MEM_WAIT_MAX) && !mem_ack;
    retire     = (state_q == EXEC && (is_cmp || is_flow)) ||
                 (state_q == MEM && is_stm && mem_ack) || state_q == WB;
    next_instr = run ? FETCH : IDLE;
    mem_req    = state_q == FETCH || state_q == MEM;
    mem_we     = state_q == MEM && is_stm;
    ir_load    = state_q == FETCH && mem_ack;
    reg_we     = state_q == WB;
    pc_load    = state_q == EXEC && (is_jmp || (is_jz && FLAG_ALU[0]));
    // JZ not taken falls through to the next instruction like any non-flow retire
    pc_inc     = (retire && !is_flow) || (state_q == EXEC && is_jz && !FLAG_ALU[0]);
    state_d    = state_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = mem_ack ? DECODE : timeout ? FAULT : FETCH;
      DECODE:  state_d = legal ? EXEC : FAULT;
      EXEC:    state_d = (is_ldm || is_stm) ? MEM : retire ? next_instr : WB;
      MEM:     state_d = timeout ? FAULT : !mem_ack ? MEM : is_ldm ? WB : next_instr;
      WB:      state_d = next_instr;
      default: state_d = FAULT;
    endcase
    wait_d      = (mem_req && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
    fault_d     = fault_q || state_d == FAULT;
    instr_cnt_d = instr_cnt_q + {7'd0, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      instr_cnt_q <= 8'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      instr_cnt_q <= instr_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign phase     = state_q;
  assign fault     = fault_q;
  assign instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: expands each instruction into its expected per-cycle behaviour
// and checks the sequencer every cycle, plus directed literal checks.
module tb_instr_sequencer;
  localparam int MAX = 7;

  logic       clk = 0, rst = 1, run = 0, mem_ack = 0;
  logic [1:0] SM = 0;
  logic [3:0] OP = 0;
  logic [2:0] FLAG_ALU = 0;
  logic       mem_req, mem_we, ir_load, reg_we, pc_inc, pc_load, fault;
  logic [2:0] phase;
  logic [7:0] instr_cnt;

  instr_sequencer #(.MEM_WAIT_MAX(MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .SM(SM), .OP(OP), .FLAG_ALU(FLAG_ALU),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
    .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load), .phase(phase),
    .fault(fault), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic chk = 0, rec = 0;
  logic [17:0] ev;
  logic [7:0] cnt_m = 0;
  logic idle_m = 1, flt_m = 0;
  int hist[$];
  int n_inc, n_load, n_rw, n_mw;

  function automatic logic [17:0] act_vec();
    return {phase, mem_req, mem_we, ir_load, reg_we, pc_inc, pc_load, fault, instr_cnt};
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk) begin
      tests++;
      if (act_vec() !== ev) begin
        fails++;
        $display("FAIL cycle t=%0t {phase,req,we,ir,rw,inc,load,fault,cnt}: got %h expected %h",
                 $time, act_vec(), ev);
      end
      if (rec) begin
        hist.push_back(int'(phase));
        n_inc += int'(pc_inc); n_load += int'(pc_load);
        n_rw += int'(reg_we); n_mw += int'(mem_we);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    hist.delete(); n_inc = 0; n_load = 0; n_rw = 0; n_mw = 0;
  endtask

  task automatic chk_hist(input string nm, input int e[$]);
    lit({nm, "_len"}, hist.size(), e.size());
    for (int i = 0; i < e.size() && i < hist.size(); i++) lit(nm, hist[i], e[i]);
  endtask

  // st = {mem_req, mem_we, ir_load, reg_we, pc_inc, pc_load, fault}
  task automatic step(input logic r, input logic [1:0] s, input logic [3:0] o,
                      input logic [2:0] f, input logic a, input logic [2:0] ph,
                      input logic [6:0] st);
    run = r; SM = s; OP = o; FLAG_ALU = f; mem_ack = a;
    ev = {ph, st, cnt_m}; chk = 1;
    @(posedge clk); #1;
  endtask

  task automatic rstep(input logic [2:0] ph, input logic [6:0] st);
    step(1'($urandom), 2'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), ph, st);
  endtask

  task automatic go_fault();
    flt_m = 1;
    repeat (4) rstep(3'd6, 7'b0000001);
  endtask

  task automatic retire_m(input logic r);
    cnt_m++;
    idle_m = !r;
  endtask

  task automatic instr(input logic [1:0] s, input logic [3:0] o, input logic [2:0] f,
                       input int fw, input int mw, input logic re);
    logic legal, ldm, stm, flow, ack, ret, pl;
    legal = s == 2 || (s == 3 ? o < 2 : o < 3);
    ldm = s == 0 && o == 1;
    stm = s == 0 && o == 2;
    flow = s == 3;
    if (idle_m) step(1'b1, 2'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 3'd0, 7'b0);
    for (int i = 0; i <= fw; i++) begin
      if (i > MAX) begin go_fault(); return; end
      step(1'($urandom), 2'($urandom), 4'($urandom), 3'($urandom), (i == fw), 3'd1,
           {1'b1, 1'b0, (i == fw), 4'b0});
    end
    step(1'($urandom), s, o, 3'($urandom), 1'($urandom), 3'd2, 7'b0);
    if (!legal) begin go_fault(); return; end
    if (flow || (s == 1 && o == 0)) begin
      pl = flow && (o == 0 || f[0]);
      step(re, s, o, f, 1'($urandom), 3'd3, {4'b0, !pl, pl, 1'b0});
      retire_m(re);
      return;
    end
    step(1'($urandom), s, o, f, 1'($urandom), 3'd3, 7'b0);
    if (ldm || stm)
      for (int i = 0; i <= mw; i++) begin
        if (i > MAX) begin go_fault(); return; end
        ack = (i == mw);
        ret = stm && ack;
        step(ret ? re : 1'($urandom), s, o, 3'($urandom), ack, 3'd4, {1'b1, stm, 2'b0, ret, 2'b0});
        if (ret) begin retire_m(re); return; end
      end
    step(re, s, o, 3'($urandom), 1'($urandom), 3'd5, {3'b0, 1'b1, 1'b1, 2'b0});
    retire_m(re);
  endtask

  task automatic do_reset();
    chk = 0; rst = 1; #1;
    lit("reset_outputs_zero", int'(act_vec()), 0);
    @(posedge clk); #1 rst = 0;
    cnt_m = 0; idle_m = 1; flt_m = 0;
  endtask

  function automatic int wsel();
    int r = $urandom_range(0, 19);
    return r < 14 ? r % 3 : (r < 18 ? MAX : MAX + 1);
  endfunction

  initial begin
    logic [1:0] s;
    logic [3:0] o;
    #1 lit("por_outputs_zero", int'(act_vec()), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    clr(); rec = 1;
    instr(2'd1, 4'd1, 3'($urandom), 0, 0, 1'b1);
    instr(2'd0, 4'd1, 3'($urandom), 0, 0, 1'b1);
    instr(2'd0, 4'd2, 3'($urandom), 0, 0, 1'b0);
    rec = 0;
    chk_hist("add_ldm_stm_phase", '{0, 1, 2, 3, 5, 1, 2, 3, 4, 5, 1, 2, 3, 4});
    lit("seq_instr_cnt", int'(instr_cnt), 3);
    lit("seq_pc_inc", n_inc, 3);
    lit("seq_reg_we", n_rw, 2);
    lit("seq_mem_we", n_mw, 1);

    clr(); rec = 1;
    instr(2'd3, 4'd1, 3'b001, 0, 0, 1'b1);
    rec = 0;
    chk_hist("jz_taken_phase", '{0, 1, 2, 3});
    lit("jz_taken_load", n_load, 1);
    lit("jz_taken_inc", n_inc, 0);
    clr(); rec = 1;
    instr(2'd3, 4'd1, 3'b000, 0, 0, 1'b0);
    rec = 0;
    chk_hist("jz_not_taken_phase", '{1, 2, 3});
    lit("jz_not_taken_load", n_load, 0);
    lit("jz_not_taken_inc", n_inc, 1);

    instr(2'd1, 4'd2, 3'($urandom), MAX, 0, 1'b1);
    lit("fetch_wait_max_no_fault", int'(fault), 0);
    instr(2'd1, 4'd1, 3'($urandom), MAX + 1, 0, 1'b1);
    lit("timeout_phase", int'(phase), 6);
    lit("timeout_fault", int'(fault), 1);
    do_reset();

    instr(2'd1, 4'd1, 3'($urandom), 0, 0, 1'b1);
    instr(2'd1, 4'd7, 3'($urandom), 0, 0, 1'b1);
    lit("illegal_cnt_unchanged", int'(instr_cnt), 1);
    lit("illegal_phase", int'(phase), 6);
    do_reset();

    instr(2'd1, 4'd1, 3'($urandom), 0, 0, 1'b1);
    instr(2'd1, 4'd1, 3'($urandom), 0, 0, 1'b1);
    instr(2'd1, 4'd1, 3'($urandom), 0, 0, 1'b0);
    lit("run_drop_phase", int'(phase), 0);
    lit("run_drop_cnt", int'(instr_cnt), 3);

    step(1'b1, 2'd0, 4'd2, 3'd0, 1'b0, 3'd0, 7'b0);
    step(1'b1, 2'd0, 4'd2, 3'd0, 1'b1, 3'd1, 7'b1010000);
    step(1'b1, 2'd0, 4'd2, 3'd0, 1'b0, 3'd2, 7'b0);
    step(1'b1, 2'd0, 4'd2, 3'd0, 1'b0, 3'd3, 7'b0);
    step(1'b1, 2'd0, 4'd2, 3'd0, 1'b0, 3'd4, 7'b1100000);
    lit("mid_stm_mem_we", int'(mem_we), 1);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      s = 2'($urandom);
      o = s == 2 ? 4'($urandom) : 4'($urandom_range(0, s == 3 ? 1 : 2));
      if ($urandom_range(0, 15) == 0) o = 4'd9;
      instr(s, o, 3'($urandom), wsel(), wsel(), 1'($urandom_range(0, 3) != 0));
      if (flt_m) do_reset();
    end

    do_reset();
    for (int n = 0; n < 256; n++) begin
      s = 2'($urandom);
      o = s == 2 ? 4'($urandom) : 4'($urandom_range(0, s == 3 ? 1 : 2));
      instr(s, o, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end
    lit("instr_cnt_wrap", int'(instr_cnt), 0);

    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the 8-bit MCU core. It steps each instruction through the fetch, decode, execute, memory and write-back phases. It handshakes with program/data memory, so memory may stall the core, and drives the PC, instruction-register, register-file and memory strobes. It sits between the instruction register's SM/OP fields and the datapath, replacing the free-running phase counter with a ready-driven FSM.

## Interface
- MEM_WAIT_MAX, 7: maximum wait cycles allowed for mem_ack before a fault is raised (1..255).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  level; 1 = keep issuing instructions, 0 = stop after the current instruction retires.
- SM  in  2  instruction class: 00 MEM, 01 ARITH, 10 LOGIC, 11 FLOW. Sampled in DECODE/EXEC/MEM/WB.
- OP  in  4  opcode within the class.
- FLAG_ALU  in  3  ALU flags; bit0 = zero.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request (FETCH, MEM states).
- mem_we  out  1  memory write qualifier (valid with mem_req).
- ir_load  out  1  load instruction register (FETCH & mem_ack).
- reg_we  out  1  register-file write strobe.
- pc_inc  out  1  PC <= PC+1 pulse.
- pc_load  out  1  PC <= jump target pulse.
- phase  out  3  current state encoding.
- fault  out  1  sticky fault flag.
- instr_cnt  out  8  retired-instruction counter.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- Legal opcodes:
  - MEM: OP 0 LDI, 1 LDM, 2 STM.
  - ARITH: OP 0 CMP, 1 ADD, 2 SUB.
  - LOGIC: any OP.
  - FLOW: OP 0 JMP, 1 JZ.
  - All other SM/OP combinations are illegal.
- IDLE: run=1 moves to FETCH; otherwise stay in IDLE.
- FETCH: mem_req=1, mem_we=0. On mem_ack, ir_load=1 in the same cycle and move to DECODE.
- DECODE: one cycle. Legal opcode moves to EXEC; illegal opcode moves to FAULT.
- EXEC: one cycle, then:
  - LDM/STM → MEM.
  - LDI, ADD, SUB, LOGIC → WB.
  - CMP retires here.
  - JMP asserts pc_load and retires.
  - JZ asserts pc_load if FLAG_ALU[0]=1, else pc_inc, and retires.
- MEM: mem_req=1; mem_we=1 only for STM. On mem_ack: LDM → WB; STM retires in the same cycle.
- WB: reg_we=1 for one cycle, then retire.
- Retire cycle:
  - Non-FLOW instructions assert pc_inc.
  - instr_cnt increments.
  - Next state is FETCH if run=1, else IDLE.
- Exactly one pc_inc or pc_load pulse is issued per retired instruction.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle in those states without mem_ack.
  - If the counter equals MEM_WAIT_MAX and mem_ack=0, next state is FAULT.
  - mem_ack is therefore accepted on up to MEM_WAIT_MAX+1 cycles.
- FAULT: all strobes are 0 and fault=1. The state is held until rst; run has no effect.
- Outputs are decoded combinationally from the state register, SM/OP, FLAG_ALU and mem_ack. Only the state, wait counter, instr_cnt and fault are flops.
- instr_cnt wraps 255→0.

## Timing
- Reset (asynchronous, immediate, including mid-instruction):
  - state=IDLE, wait counter=0, instr_cnt=0, fault=0.
  - Therefore mem_req, mem_we, ir_load, reg_we, pc_inc, pc_load are all 0 and phase=0.
- Latency with mem_ack in the first cycle of each request:
  - JMP/JZ/CMP: 3 cycles.
  - ADD/SUB/LOGIC/LDI/STM: 4 cycles.
  - LDM: 5 cycles.
  - Each memory wait cycle adds one cycle.
- Back-to-back issue: FETCH of the next instruction is in the cycle after retire, with no bubble.
- run=0 mid-instruction: the current instruction completes normally, then the FSM goes to IDLE.
- mem_ack outside FETCH/MEM is ignored.
- mem_ack on the MEM_WAIT_MAX-th wait cycle is accepted, with no fault.

## Test plan
- Reset mid-MEM of STM: assert rst → all outputs 0 and phase=0 in the same cycle; instr_cnt=0.
- run=1, immediate ack, sequence ADD, LDM, STM → phase 1,2,3,5 | 1,2,3,4,5 | 1,2,3,4; exactly one reg_we each for ADD and LDM; mem_we only in STM's MEM cycle; instr_cnt=3; three pc_inc pulses.
- JZ with FLAG_ALU=3'b001 → pc_load in EXEC and no pc_inc; JZ with FLAG_ALU=3'b000 → pc_inc and no pc_load; each takes 3 cycles.
- FETCH with ack delayed 7 cycles (MEM_WAIT_MAX=7) → ir_load on the 8th FETCH cycle, no fault; ack withheld for 8 cycles → phase=6, fault=1, held until rst.
- Illegal opcode SM=01, OP=4'b0111 → FAULT after DECODE; instr_cnt unchanged.
- run dropped during WB of the 3rd ADD → that instruction retires and phase returns to 0; 256 retired instructions → instr_cnt wraps to 0.
